c_fifo8x16: RTL and testbench
=============================

# c_fifo8x16

Eight-entry, 16-bit first-word-fall-through FIFO for the structural chip set. Storage is eight 16-bit registers written through an 8-way load demultiplexer. The read port is an 8-way 16-bit multiplexer whose 3-bit select is the FIFO read pointer. Upstream producers (keyboard scan buffer, I/O capture) push words in; the CPU-side consumer pops them with a valid/ready handshake.

## Interface
Parameters:
- None. Depth (8) and width (16) are fixed by the 8-way 16-bit read multiplexer.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `in`  in  16  write data.
- `in_valid`  in  1  producer offers `in` this cycle.
- `in_ready`  out  1  FIFO accepts a word this cycle; equals `!full`.
- `out`  out  16  head-of-queue word; forced to 0 when `empty`.
- `out_valid`  out  1  head word present; equals `!empty`.
- `out_ready`  in  1  consumer takes `out` this cycle.
- `count`  out  4  occupancy, 0..8.
- `full`  out  1  `count == 8`.
- `empty`  out  1  `count == 0`.

## Operation
- State: `wr_ptr[2:0]`, `rd_ptr[2:0]`, `count[3:0]`, and storage `mem[0..7]` of 16 bits each.
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- On push: `mem[wr_ptr] <= in` and `wr_ptr <= wr_ptr + 1` (mod 8, 7 wraps to 0).
- On pop: `rd_ptr <= rd_ptr + 1` (mod 8).
- Count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Read path is combinational: `out = empty ? 16'h0000 : mem[rd_ptr]`, selected through the 8-way 16-bit multiplexer with `sel = rd_ptr`.
- Full: `in_ready = 0`, and no push is taken even if a pop happens in the same cycle. This keeps `in_ready` free of any combinational path from `out_ready`.
- Empty: `out_valid = 0`, and `out_ready` is ignored. A word pushed while empty is visible on `out` the next cycle, not in the same cycle (no bypass).
- Simultaneous push and pop at `0 < count < 8`: both pointers advance, `count` holds. When `count == 1`, the new word becomes the head on the next cycle.
- Overflow and underflow cannot occur. `count` never exceeds 8 or goes below 0.

## Timing
- Reset, including mid-operation: on the edge where `reset = 1`:
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `mem` is not cleared.
  - Pending `in_valid`/`out_ready` in that cycle are ignored (reset has priority over push and pop).
- Output values after reset: `count = 0`, `empty = 1`, `full = 0`, `out_valid = 0`, `in_ready = 1`, `out = 16'h0000`.
- Write-to-read latency: 1 cycle (push at edge N, `out_valid` high after edge N).
- Pop-to-next-head: 1 cycle (`out` shows `mem[rd_ptr+1]` after the popping edge).
- `full`, `empty`, `in_ready`, `out_valid` and `count` are decoded from registered `count` only. They change only at clock edges.
- `out` depends combinationally on `rd_ptr`, `count` and `mem`; it has no path from `in`, `in_valid` or `out_ready`.

## Test plan
- Reset state: hold `reset = 1` for 2 cycles, then release → `count = 0`, `empty = 1`, `in_ready = 1`, `out_valid = 0`, `out = 0`.
- Fill then drain:
  - Push 16'h0001..16'h0008 on 8 consecutive cycles with `out_ready = 0` → `full = 1`, `count = 8`, `in_ready = 0`.
  - A 9th push of 16'hDEAD is not taken (`count` stays 8).
  - Drain with `out_ready = 1` → `out` reads 0001..0008 in order, then `empty = 1`, `out = 0`.
- Pointer wrap: repeat push 5 / pop 5 three times (15 words total, 16'h1000+i) → every word pops in order across the 7→0 wrap, and `count` returns to 0.
- Simultaneous events:
  - At `count = 3`, assert push and pop together for 4 cycles → `count` holds at 3 and the popped order matches push order.
  - At `count = 8`, assert push and pop together → only the pop is taken and `count = 7`.
  - At `count = 0`, assert push and pop together → only the push is taken, `count = 1`, and `out` equals the pushed word on the next cycle.
- Reset mid-operation: with `count = 5`, assert `reset` together with `in_valid = 1` and `out_ready = 1` → after the edge `count = 0`, `empty = 1`, `out = 0`. A subsequent push of 16'hBEEF appears on `out` one cycle later.
- Random soak: 2000 cycles of random `in_valid`/`out_ready` checked against a reference queue model → every popped word matches, and `count` always equals the model's occupancy.

Source files
------------

// File: rtl/c_fifo8x16.sv
// c_fifo8x16: 8-entry, 16-bit first-word-fall-through FIFO.
// Register storage behind a load demux; head read through an 8-way mux.
module c_fifo8x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  count,
  output logic        full,
  output logic        empty
);

  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic [3:0]  r_count;
  logic [15:0] r_mem [8];

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_ld;
  logic [15:0] w_head;

  assign w_full  = (r_count == 4'd8);
  assign w_empty = (r_count == 4'd0);

  // Push is gated by full alone so in_ready never sees out_ready.
  assign w_push = in_valid & ~w_full;
  assign w_pop  = out_ready & ~w_empty;

  always_comb begin
    w_ld = 8'h00;
    if (w_push) w_ld[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_ld[i]) r_mem[i] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_head = 16'h0000;
    unique case (r_rd_ptr)
      3'd0: w_head = r_mem[0];
      3'd1: w_head = r_mem[1];
      3'd2: w_head = r_mem[2];
      3'd3: w_head = r_mem[3];
      3'd4: w_head = r_mem[4];
      3'd5: w_head = r_mem[5];
      3'd6: w_head = r_mem[6];
      3'd7: w_head = r_mem[7];
      default: w_head = 16'h0000;
    endcase
  end

  assign out       = w_empty ? 16'h0000 : w_head;
  assign out_valid = ~w_empty;
  assign in_ready  = ~w_full;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule

// File: tb/tb_c_fifo8x16.sv
// tb_c_fifo8x16: directed scenarios plus a queue-model soak
// for the 8x16 FWFT FIFO.
module tb_c_fifo8x16;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_vec = 0;
  int n_err = 0;

  c_fifo8x16 dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in = 16'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (count !== 4'd0) begin
      n_err++;
      $display("FAIL rst_count got %0d want 0", count);
    end
    n_vec++;
    if (empty !== 1'b1) begin
      n_err++;
      $display("FAIL rst_empty got %b want 1", empty);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    n_vec++;
    if (out !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_out got %h want 0000", out);
    end
    n_vec++;
    if (full !== 1'b0) begin
      n_err++;
      $display("FAIL rst_full got %b want 0", full);
    end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (full !== 1'b1 || count !== 4'd8 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full full=%b count=%0d in_ready=%b want 1/8/0",
               full, count, in_ready);
    end
    in = 16'hDEAD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (count !== 4'd8) begin
      n_err++;
      $display("FAIL ninth_push count got %0d want 8", count);
    end
    n_vec++;
    if (out !== 16'h0001) begin
      n_err++;
      $display("FAIL full_head got %h want 0001", out);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      n_vec++;
      if (out !== 16'(i) || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL drain_%0d out=%h valid=%b want %h/1",
                 i, out, out_valid, 16'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (empty !== 1'b1 || out !== 16'h0000 || count !== 4'd0) begin
      n_err++;
      $display("FAIL drain_end empty=%b out=%h count=%0d want 1/0000/0",
               empty, out, count);
    end
  endtask

  task automatic test_wrap();
    int k;
    k = 0;
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        in = 16'h1000 + 16'(r * 5 + i);
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        #1;
        n_vec++;
        if (out !== 16'h1000 + 16'(k)) begin
          n_err++;
          $display("FAIL wrap_pop%0d got %h want %h",
                   k, out, 16'h1000 + 16'(k));
        end
        k++;
        tick();
      end
      out_ready = 1'b0;
    end
    #1;
    n_vec++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_end count=%0d empty=%b want 0/1", count, empty);
    end
  endtask

  task automatic test_simultaneous();
    // count = 3, then push+pop for 4 cycles
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = 16'hA000 + 16'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in = 16'hA003 + 16'(i);
      #1;
      n_vec++;
      if (out !== 16'hA000 + 16'(i)) begin
        n_err++;
        $display("FAIL both3_out%0d got %h want %h",
                 i, out, 16'hA000 + 16'(i));
      end
      tick();
      n_vec++;
      if (count !== 4'd3) begin
        n_err++;
        $display("FAIL both3_count%0d got %0d want 3", i, count);
      end
    end
    in_valid = 1'b0;
    for (int i = 4; i < 7; i++) begin
      #1;
      n_vec++;
      if (out !== 16'hA000 + 16'(i)) begin
        n_err++;
        $display("FAIL both3_tail%0d got %h want %h",
                 i, out, 16'hA000 + 16'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    // count = 8: only the pop is taken
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 16'hB000 + 16'(i);
      tick();
    end
    in = 16'hC0DE;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (count !== 4'd7 || out !== 16'hB001) begin
      n_err++;
      $display("FAIL both8 count=%0d out=%h want 7/b001", count, out);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      #1;
      n_vec++;
      if (out !== 16'hB000 + 16'(i)) begin
        n_err++;
        $display("FAIL both8_drain%0d got %h want %h",
                 i, out, 16'hB000 + 16'(i));
      end
      tick();
    end
    #1;
    n_vec++;
    if (empty !== 1'b1) begin
      n_err++;
      $display("FAIL both8_end empty got %b want 1 (c0de taken?)", empty);
    end
    // count = 0: only the push is taken
    in = 16'h5A5A;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL both0_bypass out=%h valid=%b want 0000/0",
               out, out_valid);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (count !== 4'd1 || out !== 16'h5A5A) begin
      n_err++;
      $display("FAIL both0 count=%0d out=%h want 1/5a5a", count, out);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in = 16'hE000 + 16'(i);
      tick();
    end
    n_vec++;
    if (count !== 4'd5) begin
      n_err++;
      $display("FAIL mid_pre count got %0d want 5", count);
    end
    reset = 1'b1;
    in = 16'hFFFF;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (count !== 4'd0 || empty !== 1'b1 || out !== 16'h0000) begin
      n_err++;
      $display("FAIL mid_rst count=%0d empty=%b out=%h want 0/1/0000",
               count, empty, out);
    end
    in = 16'hBEEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out !== 16'hBEEF || out_valid !== 1'b1 || count !== 4'd1) begin
      n_err++;
      $display("FAIL mid_beef out=%h valid=%b count=%0d want beef/1/1",
               out, out_valid, count);
    end
  endtask

  task automatic test_soak();
    logic [15:0] q[$];
    logic        p_push;
    logic        p_pop;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      in = 16'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      p_push = in_valid && (q.size() < 8);
      p_pop = out_ready && (q.size() > 0);
      if (p_pop) begin
        n_vec++;
        if (out !== q[0]) begin
          n_err++;
          $display("FAIL soak_pop cyc%0d got %h want %h", c, out, q[0]);
        end
      end
      tick();
      if (p_pop) void'(q.pop_front());
      if (p_push) q.push_back(in);
      n_vec++;
      if (count !== 4'(q.size())) begin
        n_err++;
        $display("FAIL soak_count cyc%0d got %0d want %0d",
                 c, count, q.size());
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in = 16'h0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
